// File: rtl/multicycle_control_fsm.sv
// Main sequencing FSM for the multi-cycle RV32I core: drives datapath selects,
// write enables, the ALU decoder's aluOp and the retired-instruction counter.
//
// state    | meaning
// ---------+----------------------------------------------------
// FETCH    | read instruction at PC, PC <= PC+4 when memory ready
// DECODE   | register read, branch/jump target into aluOut
// MEMADR   | compute load/store effective address
// MEMREAD  | load data read, wait for memory
// MEMWB    | write load data into rd
// MEMWRITE | store data write, wait for memory
// EXECUTER | R-type ALU operation
// EXECUTEI | I-type ALU operation
// ALUWB    | write aluOut into rd
// BEQ      | compare rs1/rs2, take branch on zero
// JAL      | PC <= target, aluOut <= oldPC+4
module multicycle_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic             zero,
  input  logic             memReady,
  output logic             pcWrite,
  output logic             adrSrc,
  output logic             memWrite,
  output logic             irWrite,
  output logic [1:0]       resultSrc,
  output logic [1:0]       aluSrcA,
  output logic [1:0]       aluSrcB,
  output logic [1:0]       aluOp,
  output logic [1:0]       immSrc,
  output logic             regWrite,
  output logic             illegalOp,
  output logic [CNT_W-1:0] instret
);

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  state_t state, state_nxt;
  logic   pc_update, branch, ir_wr, mem_wr, reg_wr, illegal, retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instret <= '0;
    else if (retire) instret <= instret + CNT_W'(1);
  end

  always_comb begin
    state_nxt = state;
    pc_update = 1'b0;
    branch    = 1'b0;
    ir_wr     = 1'b0;
    mem_wr    = 1'b0;
    reg_wr    = 1'b0;
    illegal   = 1'b0;
    retire    = 1'b0;
    adrSrc    = 1'b0;
    resultSrc = 2'b00;
    aluSrcA   = 2'b00;
    aluSrcB   = 2'b00;
    aluOp     = 2'b00;
    case (state)
      S_FETCH: begin
        aluSrcB   = 2'b10;
        resultSrc = 2'b10;
        ir_wr     = memReady;
        pc_update = memReady;
        if (memReady) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        aluSrcA = 2'b01;
        aluSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = S_EXECUTER;
          OP_ITYPE:     state_nxt = S_EXECUTEI;
          OP_BEQ:       state_nxt = S_BEQ;
          OP_JAL:       state_nxt = S_JAL;
          default: begin
            state_nxt = S_FETCH;
            illegal   = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        aluSrcA   = 2'b10;
        aluSrcB   = 2'b01;
        state_nxt = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adrSrc = 1'b1;
        if (memReady) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        resultSrc = 2'b01;
        reg_wr    = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_MEMWRITE: begin
        adrSrc = 1'b1;
        mem_wr = 1'b1;
        if (memReady) begin
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_EXECUTER: begin
        aluSrcA   = 2'b10;
        aluOp     = 2'b10;
        state_nxt = S_ALUWB;
      end
      S_EXECUTEI: begin
        aluSrcA   = 2'b10;
        aluSrcB   = 2'b01;
        aluOp     = 2'b10;
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        reg_wr    = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BEQ: begin
        aluSrcA   = 2'b10;
        aluOp     = 2'b01;
        branch    = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_JAL: begin
        aluSrcA   = 2'b01;
        aluSrcB   = 2'b10;
        pc_update = 1'b1;
        state_nxt = S_ALUWB;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   immSrc = 2'b01;
      OP_BEQ:  immSrc = 2'b10;
      OP_JAL:  immSrc = 2'b11;
      default: immSrc = 2'b00;
    endcase
  end

  // Reset drops enables immediately so an in-flight access is abandoned.
  assign pcWrite   = rst_n & (pc_update | (branch & zero));
  assign irWrite   = rst_n & ir_wr;
  assign memWrite  = rst_n & mem_wr;
  assign regWrite  = rst_n & reg_wr;
  assign illegalOp = rst_n & illegal;

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Main control state machine for the multi-cycle variant of the RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives the datapath mux selects and write enables. It also produces the 2-bit `aluOp` consumed by `ALU_Decoder`: 00 = add, 01 = subtract/compare, 10 = decode from `funct3`/`funct7`. It supports lw, sw, R-type, I-type ALU, beq and jal, with a memory wait handshake and a retired-instruction counter.

## Interface
- `CNT_W`, 32, width of retired-instruction counter `instret`
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `op`  in  7  opcode field from the instruction register (stable from DECODE onward)
- `zero`  in  1  ALU zero flag
- `memReady`  in  1  memory completes the current access this cycle
- `pcWrite`  out  1  PC register enable
- `adrSrc`  out  1  memory address select: 0 = PC, 1 = ALU result register
- `memWrite`  out  1  data memory write strobe
- `irWrite`  out  1  instruction register and oldPC enable
- `resultSrc`  out  2  result mux: 00 = aluOut, 01 = readData, 10 = raw ALU result
- `aluSrcA`  out  2  00 = PC, 01 = oldPC, 10 = rs1 register
- `aluSrcB`  out  2  00 = rs2 register, 01 = immExt, 10 = constant 4
- `aluOp`  out  2  to `ALU_Decoder`
- `immSrc`  out  2  00 = I, 01 = S, 10 = B, 11 = J
- `regWrite`  out  1  register file write enable
- `illegalOp`  out  1  one-cycle pulse when an unsupported opcode is decoded
- `instret`  out  CNT_W  count of retired instructions

## Operation
- State register is 4-bit and encodes 11 states. It resets to FETCH. All outputs are decoded from the state, `op`, `zero` and `memReady`.
- Any output not listed for a state is 0.
- `pcWrite` = `pcUpdate` | (`branch` & `zero`), where `pcUpdate` and `branch` are internal signals.
- `immSrc` is purely combinational from `op`, independent of state:
  - 0000011 and 0010011 → 00
  - 0100011 → 01
  - 1100011 → 10
  - 1101111 → 11
  - any other → 00
- **FETCH:** `adrSrc`=0, `aluSrcA`=00, `aluSrcB`=10, `aluOp`=00, `resultSrc`=10.
  - `irWrite`=`pcUpdate`=`memReady`.
  - Moves to DECODE when `memReady`=1, otherwise stays.
- **DECODE:** `aluSrcA`=01, `aluSrcB`=01, `aluOp`=00 (branch/jump target into aluOut). Next state by `op`:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1100011 → BEQ
  - 1101111 → JAL
  - any other → FETCH, with `illegalOp`=1 for this cycle
- **MEMADR:** `aluSrcA`=10, `aluSrcB`=01, `aluOp`=00. Next is MEMREAD if `op`=0000011, else MEMWRITE.
- **MEMREAD:** `adrSrc`=1, `resultSrc`=00. Moves to MEMWB when `memReady`, otherwise holds.
- **MEMWB:** `resultSrc`=01, `regWrite`=1. Next is FETCH.
- **MEMWRITE:** `adrSrc`=1, `resultSrc`=00, `memWrite`=1 for every cycle spent in the state. Moves to FETCH when `memReady`, otherwise holds.
- **EXECUTER:** `aluSrcA`=10, `aluSrcB`=00, `aluOp`=10. Next is ALUWB.
- **EXECUTEI:** `aluSrcA`=10, `aluSrcB`=01, `aluOp`=10. Next is ALUWB.
- **ALUWB:** `resultSrc`=00, `regWrite`=1. Next is FETCH.
- **BEQ:** `aluSrcA`=10, `aluSrcB`=00, `aluOp`=01, `resultSrc`=00, `branch`=1. Next is FETCH.
- **JAL:** `aluSrcA`=01, `aluSrcB`=10, `aluOp`=00, `resultSrc`=00, `pcUpdate`=1. Next is ALUWB (writes PC+4 to rd).
- **Retirement:** `instret` increments by 1 on every transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ.
  - The illegal-op path DECODE → FETCH does not count.
  - `instret` wraps modulo 2^CNT_W.
- Unreachable state encodings go to FETCH on the next edge, with all enables 0 while in them.

## Timing
- **Reset:**
  - While `rst_n`=0: state=FETCH and `instret`=0.
  - `pcWrite`, `irWrite`, `memWrite`, `regWrite` and `illegalOp` are forced to 0. Mux selects show the FETCH values.
  - Reset is asynchronous, so an instruction in flight is abandoned with no register or memory write.
  - After deassertion, the first edge with `memReady`=1 in FETCH latches the instruction.
- **Cycle counts with `memReady` held at 1:**
  - beq: 3
  - R-type, I-type, sw, jal: 4
  - lw: 5
  - Each memory wait cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- **Memory handshake:** `memReady` is sampled on the clock edge only in FETCH, MEMREAD and MEMWRITE; it is ignored in all other states.
- **Branch:** `zero` is combinational into `pcWrite` in BEQ. It must settle within the same cycle.
- **Output timing:** `illegalOp` and all write enables are high for exactly the cycles listed above, with no glitch-free guarantee beyond synchronous use.

## Test plan
- **Reset:** assert `rst_n`=0 mid-MEMWRITE with `memReady`=0 → `memWrite` falls to 0 immediately; state=FETCH; `instret`=0; after release, `irWrite` and `pcWrite` are 0 until `memReady`=1.
- **R-type add:** `op`=0110011, `memReady`=1 → FETCH, DECODE, EXECUTER (`aluOp`=10, `aluSrcA`=10, `aluSrcB`=00), ALUWB (`regWrite`=1), then FETCH; `instret` goes 0 → 1.
- **lw with waits:** `op`=0000011, `memReady` low 2 cycles in FETCH and 3 cycles in MEMREAD → 10 cycles total; `regWrite` high once, in MEMWB, with `resultSrc`=01; `immSrc`=00.
- **beq both ways:** `op`=1100011 → with `zero`=1, `pcWrite`=1 in BEQ; with `zero`=0, `pcWrite`=0; both take 3 cycles, `aluOp`=01, `immSrc`=10, and `instret` increments.
- **jal:** `op`=1101111 → JAL asserts `pcWrite`=1 with `aluSrcA`=01 and `aluSrcB`=10, then ALUWB with `regWrite`=1; 4 cycles; `immSrc`=11.
- **Illegal opcode:** `op`=1110011 → one-cycle `illegalOp` pulse in DECODE, return to FETCH, no `regWrite`/`memWrite`, `instret` unchanged. Separately, preload `instret`=2^32−1 via a retired sw → value wraps to 0.
